// File: rtl/lsu.sv
// Load/store unit: runs one ex memory request at a time through IDLE/RD/CAP/WR/RSP,
// doing sub-word stores as read-modify-write and returning extended load data.
module lsu #(
    parameter int ADDR_W     = 32,
    parameter int RAM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic [4:0]        rsp_rd_o,
    output logic              rsp_err_o,
    output logic              busy_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic [2:0]        state_dbg
);
    // Handshake: a request transfers on a rising edge where req_valid_i && req_ready_o;
    // ex keeps the request stable until then, and ready is high only in IDLE.
    typedef enum logic [2:0] {IDLE = 3'd0, RD = 3'd1, CAP = 3'd2, WR = 3'd3, RSP = 3'd4} state_t;

    state_t            state, state_nx;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [4:0]        rd_q;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] raddr_q;
    logic [31:0]       mwdata_q;
    logic [31:0]       rdata_q;
    logic [4:0]        rsp_rd_q;
    logic              err_q;

    logic              accept, bad, need_rd;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       ld_ext, merged;

    function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic r;
        if (we) begin
            case (f3)
                3'd0:    r = 1'b0;
                3'd1:    r = a[0];
                3'd2:    r = (a != 2'b00);
                default: r = 1'b1;
            endcase
        end else begin
            case (f3)
                3'd0, 3'd4: r = 1'b0;
                3'd1, 3'd5: r = a[0];
                3'd2:       r = (a != 2'b00);
                default:    r = 1'b1;
            endcase
        end
        return r;
    endfunction

    assign accept  = req_valid_i && (state == IDLE);
    assign bad     = req_bad(req_we_i, req_funct3_i, req_addr_i[1:0]);
    // Everything except SW needs the old word first.
    assign need_rd = !req_we_i || (req_funct3_i != 3'd2);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = bad ? RSP : (need_rd ? RD : WR);
            RD:   state_nx = CAP;
            CAP:  if (cnt == 2'd0) state_nx = we_q ? WR : RSP;
            WR:   state_nx = RSP;
            RSP:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        lane_b = 8'h00;
        case (addr_q[1:0])
            2'd0: lane_b = mem_rdata_i[7:0];
            2'd1: lane_b = mem_rdata_i[15:8];
            2'd2: lane_b = mem_rdata_i[23:16];
            2'd3: lane_b = mem_rdata_i[31:24];
            default: lane_b = 8'h00;
        endcase
        lane_h = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (f3_q)
            3'd0:    ld_ext = {{24{lane_b[7]}}, lane_b};
            3'd1:    ld_ext = {{16{lane_h[15]}}, lane_h};
            3'd4:    ld_ext = {24'h000000, lane_b};
            3'd5:    ld_ext = {16'h0000, lane_h};
            default: ld_ext = mem_rdata_i;
        endcase
        merged = mem_rdata_i;
        if (f3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        else         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            f3_q     <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 16'h0000;
            rd_q     <= 5'd0;
            cnt      <= 2'd0;
            raddr_q  <= '0;
            mwdata_q <= 32'h0;
            rdata_q  <= 32'h0;
            rsp_rd_q <= 5'd0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q    <= req_we_i;
                f3_q    <= req_funct3_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i[15:0];
                rd_q    <= req_rd_i;
                if (bad) begin
                    rdata_q  <= 32'h0;
                    rsp_rd_q <= req_rd_i;
                    err_q    <= 1'b1;
                end else if (need_rd) begin
                    raddr_q <= {req_addr_i[ADDR_W-1:2], 2'b00};
                end else begin
                    mwdata_q <= req_wdata_i;
                end
            end
            if (state == RD) cnt <= 2'(RAM_RD_LAT - 1);
            if (state == CAP) begin
                if (cnt != 2'd0) begin
                    cnt <= cnt - 2'd1;
                end else if (we_q) begin
                    mwdata_q <= merged;
                end else begin
                    rdata_q  <= ld_ext;
                    rsp_rd_q <= rd_q;
                    err_q    <= 1'b0;
                end
            end
            if (state == WR) begin
                rdata_q  <= 32'h0;
                rsp_rd_q <= 5'd0;
                err_q    <= 1'b0;
            end
        end
    end

    assign req_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign rsp_valid_o = (state == RSP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_rd_o    = rsp_rd_q;
    assign rsp_err_o   = err_q;
    assign mem_we_o    = (state == WR) && !rst;
    assign mem_waddr_o = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_raddr_o = raddr_q;
    assign mem_wdata_o = mwdata_q;
    assign state_dbg   = state;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: two instances (ram read latency 1 and 2) sharing clock and reset,
// each backed by a small word RAM model with the matching read pipeline.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [4:0]  req_rd     [2];
    logic        rsp_valid  [2];
    logic [31:0] rsp_rdata  [2];
    logic [4:0]  rsp_rd     [2];
    logic        rsp_err    [2];
    logic        busy       [2];
    logic        mem_we     [2];
    logic [31:0] mem_waddr  [2];
    logic [31:0] mem_raddr  [2];
    logic [31:0] mem_wdata  [2];
    logic [31:0] mem_rdata  [2];
    logic [2:0]  state_dbg  [2];

    logic [31:0] ram [2][64];
    logic [31:0] rp1 [2];
    logic [31:0] rp2 [2];
    int          we_cnt [2];
    logic [31:0] last_waddr [2];
    logic [31:0] last_wdata [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(32), .RAM_RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
        .req_funct3_i(req_funct3[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .req_rd_i(req_rd[0]), .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]),
        .rsp_rd_o(rsp_rd[0]), .rsp_err_o(rsp_err[0]), .busy_o(busy[0]), .mem_we_o(mem_we[0]),
        .mem_waddr_o(mem_waddr[0]), .mem_raddr_o(mem_raddr[0]), .mem_wdata_o(mem_wdata[0]),
        .mem_rdata_i(mem_rdata[0]), .state_dbg(state_dbg[0])
    );

    lsu #(.ADDR_W(32), .RAM_RD_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
        .req_funct3_i(req_funct3[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .req_rd_i(req_rd[1]), .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]),
        .rsp_rd_o(rsp_rd[1]), .rsp_err_o(rsp_err[1]), .busy_o(busy[1]), .mem_we_o(mem_we[1]),
        .mem_waddr_o(mem_waddr[1]), .mem_raddr_o(mem_raddr[1]), .mem_wdata_o(mem_wdata[1]),
        .mem_rdata_i(mem_rdata[1]), .state_dbg(state_dbg[1])
    );

    initial begin
        for (int i = 0; i < 2; i++) begin
            we_cnt[i]     = 0;
            last_waddr[i] = 32'h0;
            last_wdata[i] = 32'h0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_we[i]) begin
                ram[i][mem_waddr[i][7:2]] <= mem_wdata[i];
                we_cnt[i]     <= we_cnt[i] + 1;
                last_waddr[i] <= mem_waddr[i];
                last_wdata[i] <= mem_wdata[i];
            end
            rp1[i] <= ram[i][mem_raddr[i][7:2]];
            rp2[i] <= rp1[i];
        end
    end

    always_comb begin
        mem_rdata[0] = rp1[0];
        mem_rdata[1] = rp2[1];
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] exp_rdata;
        logic [4:0]  exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs1 [22];
    vec_t vecs2 [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_req(input int d, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd, output int lat,
                          output logic [31:0] rdata, output logic [4:0] rrd, output logic rerr,
                          output logic busy_ok);
        bit got;
        @(posedge clk); #1;
        req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
        req_addr[d] = addr; req_wdata[d] = wdata; req_rd[d] = rd;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 0; got = 0; busy_ok = 1'b1;
        rdata = 32'h0; rrd = 5'd0; rerr = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (!busy[d]) busy_ok = 1'b0;
            if (rsp_valid[d]) begin
                got = 1; rdata = rsp_rdata[d]; rrd = rsp_rd[d]; rerr = rsp_err[d];
            end
        end
        @(negedge clk);
        chk("rsp_pulse_one_cycle", {31'd0, rsp_valid[d]}, 32'd0);
        chk("ready_after_rsp", {31'd0, req_ready[d]}, 32'd1);
    endtask

    task automatic run_vec(input int d, input vec_t v, input int idx);
        int lat, w0;
        logic [31:0] rdata;
        logic [4:0] rrd;
        logic rerr, busy_ok;
        string tag;
        tag = $sformatf("d%0d_v%0d", d, idx);
        w0 = we_cnt[d];
        do_req(d, v.we, v.f3, v.addr, v.wdata, v.rd, lat, rdata, rrd, rerr, busy_ok);
        chk({tag, "_rdata"}, rdata, v.exp_rdata);
        chk({tag, "_rd"}, {27'd0, rrd}, {27'd0, v.exp_rd});
        chk({tag, "_err"}, {31'd0, rerr}, {31'd0, v.exp_err});
        chk({tag, "_lat"}, lat, v.exp_lat);
        chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, "_writes"}, we_cnt[d] - w0, v.exp_wr);
        if (v.exp_wr != 0) begin
            chk({tag, "_wdata"}, last_wdata[d], v.exp_wdata);
            chk({tag, "_waddr"}, last_waddr[d], v.addr & 32'hFFFF_FFFC);
        end
    endtask

    initial begin
        int k, w0, rsp1_k, rsp2_k, lat;
        logic [31:0] d1, rdata;
        logic [4:0] rrd;
        logic rerr, busy_ok, busy_bad;

        //           we    f3    addr   wdata          rd     exp_rdata      rd     err  lat wr  wdata
        vecs1[0]  = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd1,  32'h0,         5'd0,  1'b0, 2, 1, 32'hDEADBEEF};
        vecs1[1]  = '{1'b1, 3'd0, 32'h11, 32'h123456AA, 5'd2,  32'h0,         5'd0,  1'b0, 4, 1, 32'hDEADAAEF};
        vecs1[2]  = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd3,  32'h0,         5'd0,  1'b0, 2, 1, 32'hDEADBEEF};
        vecs1[3]  = '{1'b1, 3'd1, 32'h12, 32'h00005555, 5'd4,  32'h0,         5'd0,  1'b0, 4, 1, 32'h5555BEEF};
        vecs1[4]  = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd0,  32'h0,         5'd0,  1'b0, 2, 1, 32'hDEADBEEF};
        vecs1[5]  = '{1'b1, 3'd2, 32'h14, 32'h01234567, 5'd0,  32'h0,         5'd0,  1'b0, 2, 1, 32'h01234567};
        vecs1[6]  = '{1'b0, 3'd0, 32'h13, 32'h0,        5'd5,  32'hFFFFFFDE,  5'd5,  1'b0, 3, 0, 32'h0};
        vecs1[7]  = '{1'b0, 3'd4, 32'h13, 32'h0,        5'd6,  32'h000000DE,  5'd6,  1'b0, 3, 0, 32'h0};
        vecs1[8]  = '{1'b0, 3'd1, 32'h12, 32'h0,        5'd7,  32'hFFFFDEAD,  5'd7,  1'b0, 3, 0, 32'h0};
        vecs1[9]  = '{1'b0, 3'd5, 32'h10, 32'h0,        5'd8,  32'h0000BEEF,  5'd8,  1'b0, 3, 0, 32'h0};
        vecs1[10] = '{1'b0, 3'd2, 32'h10, 32'h0,        5'd9,  32'hDEADBEEF,  5'd9,  1'b0, 3, 0, 32'h0};
        vecs1[11] = '{1'b0, 3'd0, 32'h10, 32'h0,        5'd10, 32'hFFFFFFEF,  5'd10, 1'b0, 3, 0, 32'h0};
        vecs1[12] = '{1'b0, 3'd1, 32'h10, 32'h0,        5'd11, 32'hFFFFBEEF,  5'd11, 1'b0, 3, 0, 32'h0};
        vecs1[13] = '{1'b0, 3'd4, 32'h14, 32'h0,        5'd12, 32'h00000067,  5'd12, 1'b0, 3, 0, 32'h0};
        vecs1[14] = '{1'b0, 3'd5, 32'h16, 32'h0,        5'd13, 32'h00000123,  5'd13, 1'b0, 3, 0, 32'h0};
        vecs1[15] = '{1'b0, 3'd2, 32'h12, 32'h0,        5'd14, 32'h0,         5'd14, 1'b1, 1, 0, 32'h0};
        vecs1[16] = '{1'b1, 3'd1, 32'h11, 32'h00005555, 5'd15, 32'h0,         5'd15, 1'b1, 1, 0, 32'h0};
        vecs1[17] = '{1'b0, 3'd3, 32'h10, 32'h0,        5'd16, 32'h0,         5'd16, 1'b1, 1, 0, 32'h0};
        vecs1[18] = '{1'b1, 3'd3, 32'h10, 32'h11111111, 5'd17, 32'h0,         5'd17, 1'b1, 1, 0, 32'h0};
        vecs1[19] = '{1'b0, 3'd6, 32'h10, 32'h0,        5'd18, 32'h0,         5'd18, 1'b1, 1, 0, 32'h0};
        vecs1[20] = '{1'b1, 3'd0, 32'h17, 32'h000000FF, 5'd19, 32'h0,         5'd0,  1'b0, 4, 1, 32'hFF234567};
        vecs1[21] = '{1'b0, 3'd0, 32'h17, 32'h0,        5'd20, 32'hFFFFFFFF,  5'd20, 1'b0, 3, 0, 32'h0};

        vecs2[0]  = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd1,  32'h0,         5'd0,  1'b0, 2, 1, 32'hDEADBEEF};
        vecs2[1]  = '{1'b0, 3'd2, 32'h10, 32'h0,        5'd3,  32'hDEADBEEF,  5'd3,  1'b0, 4, 0, 32'h0};
        vecs2[2]  = '{1'b1, 3'd0, 32'h11, 32'h000000AA, 5'd4,  32'h0,         5'd0,  1'b0, 5, 1, 32'hDEADAAEF};
        vecs2[3]  = '{1'b0, 3'd1, 32'h12, 32'h0,        5'd5,  32'hFFFFDEAD,  5'd5,  1'b0, 4, 0, 32'h0};
        vecs2[4]  = '{1'b0, 3'd2, 32'h11, 32'h0,        5'd6,  32'h0,         5'd6,  1'b1, 1, 0, 32'h0};

        // clock/reset
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_funct3[i] = 3'd0;
            req_addr[i] = 32'h0; req_wdata[i] = 32'h0; req_rd[i] = 5'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_ready", {31'd0, req_ready[i]}, 32'd1);
            chk("reset_busy", {31'd0, busy[i]}, 32'd0);
            chk("reset_rsp_valid", {31'd0, rsp_valid[i]}, 32'd0);
            chk("reset_mem_we", {31'd0, mem_we[i]}, 32'd0);
            chk("reset_rdata", rsp_rdata[i], 32'd0);
            chk("reset_raddr", mem_raddr[i], 32'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 22; i++) run_vec(0, vecs1[i], i);

        // Back-to-back: valid held high, LW then SW.
        w0 = we_cnt[0]; rsp1_k = 0; rsp2_k = 0; d1 = 32'h0; busy_bad = 1'b0;
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_funct3[0] = 3'd2;
        req_addr[0] = 32'h10; req_wdata[0] = 32'h0; req_rd[0] = 5'd21;
        @(posedge clk); #1;
        req_we[0] = 1'b1; req_addr[0] = 32'h18; req_wdata[0] = 32'hCAFEF00D; req_rd[0] = 5'd22;
        for (k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 5) req_valid[0] = 1'b0;
            if (k != 4 && k <= 6 && !busy[0]) busy_bad = 1'b1;
            if (rsp_valid[0] && rsp1_k == 0) begin
                rsp1_k = k; d1 = rsp_rdata[0];
                chk("b2b_first_rd", {27'd0, rsp_rd[0]}, 32'd21);
            end else if (rsp_valid[0] && rsp2_k == 0) begin
                rsp2_k = k;
                chk("b2b_second_rd", {27'd0, rsp_rd[0]}, 32'd0);
                chk("b2b_second_err", {31'd0, rsp_err[0]}, 32'd0);
            end
            if (k == 4) chk("b2b_ready_after_rsp", {31'd0, req_ready[0]}, 32'd1);
        end
        chk("b2b_first_k", rsp1_k, 3);
        chk("b2b_first_data", d1, 32'hDEADBEEF);
        chk("b2b_second_k", rsp2_k, 6);
        chk("b2b_busy", {31'd0, busy_bad}, 32'd0);
        chk("b2b_writes", we_cnt[0] - w0, 1);
        chk("b2b_wdata", last_wdata[0], 32'hCAFEF00D);
        chk("b2b_waddr", last_waddr[0], 32'h18);

        // Reset in CAP of an SB: leave a nonzero response first.
        do_req(0, 1'b0, 3'd2, 32'h14, 32'h0, 5'd23, lat, rdata, rrd, rerr, busy_ok);
        chk("pre_rst_rdata", rdata, 32'hFF234567);
        w0 = we_cnt[0];
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'd0;
        req_addr[0] = 32'h10; req_wdata[0] = 32'h00000011; req_rd[0] = 5'd0;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rst_seq_state_rd", {29'd0, state_dbg[0]}, 32'd1);
        @(negedge clk);
        chk("rst_seq_state_cap", {29'd0, state_dbg[0]}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_state_idle", {29'd0, state_dbg[0]}, 32'd0);
        chk("rst_ready", {31'd0, req_ready[0]}, 32'd1);
        chk("rst_busy", {31'd0, busy[0]}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk("rst_rdata", rsp_rdata[0], 32'd0);
        chk("rst_rsp_rd", {27'd0, rsp_rd[0]}, 32'd0);
        chk("rst_err", {31'd0, rsp_err[0]}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we[0]}, 32'd0);
        chk("rst_waddr", mem_waddr[0], 32'd0);
        chk("rst_raddr", mem_raddr[0], 32'd0);
        chk("rst_wdata", mem_wdata[0], 32'd0);
        repeat (5) @(negedge clk);
        chk("rst_no_write", we_cnt[0] - w0, 0);
        do_req(0, 1'b0, 3'd2, 32'h10, 32'h0, 5'd24, lat, rdata, rrd, rerr, busy_ok);
        chk("rst_ram_intact", rdata, 32'hDEADBEEF);

        for (int i = 0; i < 5; i++) run_vec(1, vecs2[i], i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
